uart_rx_deframer: RTL and testbench

// - Consumes the per-bit majority decisions (bit_in/bit_valid) produced by the UART oversampling sampler.
// - Assembles one frame: start bit, DATA_BITS data bits LSB-first, optional parity, STOP_BITS stop bits.
// - Presents the received byte on a valid/ready interface with parity, frame and overrun status.
// - Pulses sampler_stop at the end of every frame so the sampler re-arms its start-bit search.

---
 rtl/uart_rx_deframer.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx_deframer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer
// Turns the sampler's per-bit decisions into UART frames: start bit,
// DATA_BITS data bits LSB-first, optional parity bit, then STOP_BITS stop
// bits. Each finished frame is offered on a valid/ready output together
// with its parity and framing status. A sticky overrun flag records frames
// that were dropped.
//
// Ports
//   clk, rst_n    system clock (rising edge); asynchronous active-low reset
//   bit_in        sampled line bit, qualified by bit_valid
//   bit_valid     1-clk strobe from the sampler
//   sampler_stop  1-clk pulse at end of frame; re-arms the sampler
//   rx_data       received data; bit 0 is the first data bit on the line
//   rx_valid      rx_data / err_* are valid
//   rx_ready      consumer accepts the frame
//   err_parity    parity mismatch for the frame in rx_data
//   err_frame     a stop bit of the frame in rx_data was sampled 0
//   overrun       sticky: a completed frame was dropped
//   clr_ovr       1-clk pulse that clears overrun
//   dbg_state     current FSM state, for observation only
//
// Output handshake: a frame transfers on every clk where rx_valid and
// rx_ready are both 1. rx_valid then falls on the next clk unless a new
// frame commits in that same clk. Once rx_valid is 1, rx_data and err_*
// stay stable until the frame is taken. They also keep their values after
// the transfer, until the next commit. If a frame completes while an
// untaken frame is still held, the new frame is dropped and overrun is set.

module uart_rx_deframer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  input  logic                 bit_valid,
  output logic                 sampler_stop,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 err_parity,
  output logic                 err_frame,
  output logic                 overrun,
  input  logic                 clr_ovr,
  output logic [2:0]           dbg_state
);

  localparam int unsigned     CW        = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0]   LAST_BIT  = CW'(DATA_BITS - 1);
  localparam logic            LAST_STOP = (STOP_BITS == 2);
  localparam logic            PAR_ON    = (PARITY_EN != 0);
  localparam logic            PAR_ODD   = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_START = 3'd0,
    S_DATA  = 3'd1,
    S_PAR   = 3'd2,
    S_STOP  = 3'd3,
    S_END   = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   acc_q, acc_d;
  logic                   par_bad_q, par_bad_d;
  logic                   stop_bad_q, stop_bad_d;
  logic                   stop_cnt_q, stop_cnt_d;
  logic                   sampler_stop_q, sampler_stop_d;
  logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   err_parity_q, err_parity_d;
  logic                   err_frame_q, err_frame_d;
  logic                   overrun_q, overrun_d;
  logic                   commit;
  logic                   ovr_set;

  // Frame FSM. Every transition into S_END happens on the edge that
  // consumes the last bit. So sampler_stop and the commit become visible
  // together, during the single S_END clk.
  always_comb begin
    state_d        = state_q;
    shift_d        = shift_q;
    bit_cnt_d      = bit_cnt_q;
    acc_d          = acc_q;
    par_bad_d      = par_bad_q;
    stop_bad_d     = stop_bad_q;
    stop_cnt_d     = stop_cnt_q;
    sampler_stop_d = 1'b0;
    commit         = 1'b0;
    case (state_q)
      S_START: begin
        if (bit_valid) begin
          if (!bit_in) begin
            state_d    = S_DATA;
            bit_cnt_d  = '0;
            acc_d      = 1'b0;
            par_bad_d  = 1'b0;
            stop_bad_d = 1'b0;
            stop_cnt_d = 1'b0;
          end else begin
            // False start: end the frame without delivering anything.
            state_d        = S_END;
            sampler_stop_d = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (bit_valid) begin
          shift_d   = {bit_in, shift_q[DATA_BITS-1:1]};
          acc_d     = acc_q ^ bit_in;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = PAR_ON ? S_PAR : S_STOP;
          end
        end
      end
      S_PAR: begin
        if (bit_valid) begin
          par_bad_d = acc_q ^ bit_in ^ PAR_ODD;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_valid) begin
          stop_bad_d = stop_bad_q | ~bit_in;
          if (stop_cnt_q == LAST_STOP) begin
            state_d        = S_END;
            sampler_stop_d = 1'b1;
            commit         = 1'b1;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      S_END: begin
        state_d = S_START;
      end
      default: begin
        state_d = S_START;
      end
    endcase
  end

  // Output holding register and overrun tracking. Commit uses stop_bad_d
  // so that the last stop bit, consumed on this same edge, is included.
  always_comb begin
    rx_valid_d   = rx_valid_q & ~rx_ready;
    rx_data_d    = rx_data_q;
    err_parity_d = err_parity_q;
    err_frame_d  = err_frame_q;
    ovr_set      = 1'b0;
    if (commit) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d    = shift_q;
        err_parity_d = par_bad_q;
        err_frame_d  = stop_bad_d;
        rx_valid_d   = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
    end
    // If a set and a clear arrive in the same clk, the set wins.
    overrun_d = ovr_set | (overrun_q & ~clr_ovr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_START;
      shift_q        <= '0;
      bit_cnt_q      <= '0;
      acc_q          <= 1'b0;
      par_bad_q      <= 1'b0;
      stop_bad_q     <= 1'b0;
      stop_cnt_q     <= 1'b0;
      sampler_stop_q <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      err_parity_q   <= 1'b0;
      err_frame_q    <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      shift_q        <= shift_d;
      bit_cnt_q      <= bit_cnt_d;
      acc_q          <= acc_d;
      par_bad_q      <= par_bad_d;
      stop_bad_q     <= stop_bad_d;
      stop_cnt_q     <= stop_cnt_d;
      sampler_stop_q <= sampler_stop_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      err_parity_q   <= err_parity_d;
      err_frame_q    <= err_frame_d;
      overrun_q      <= overrun_d;
    end
  end

  assign sampler_stop = sampler_stop_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign err_parity   = err_parity_q;
  assign err_frame    = err_frame_q;
  assign overrun      = overrun_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer with three configurations:
//   d=0: 8N1, d=1: 8 data bits with even parity and 1 stop bit,
//   d=2: 5 data bits with odd parity and 2 stop bits.
module tb_uart_rx_deframer;

  logic       clk;
  logic       rst_n;
  logic [2:0] bit_in, bit_valid, rx_ready, clr_ovr;
  logic [2:0] ss, rv, ep, ef, ov;
  logic [7:0] rd0, rd1;
  logic [4:0] rd2;
  logic [2:0] dbg0, dbg1, dbg2;

  int checks = 0;
  int errors = 0;

  uart_rx_deframer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_d0 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in[0]), .bit_valid(bit_valid[0]),
    .sampler_stop(ss[0]), .rx_data(rd0), .rx_valid(rv[0]), .rx_ready(rx_ready[0]),
    .err_parity(ep[0]), .err_frame(ef[0]), .overrun(ov[0]), .clr_ovr(clr_ovr[0]),
    .dbg_state(dbg0));

  uart_rx_deframer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in[1]), .bit_valid(bit_valid[1]),
    .sampler_stop(ss[1]), .rx_data(rd1), .rx_valid(rv[1]), .rx_ready(rx_ready[1]),
    .err_parity(ep[1]), .err_frame(ef[1]), .overrun(ov[1]), .clr_ovr(clr_ovr[1]),
    .dbg_state(dbg1));

  uart_rx_deframer #(.DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in[2]), .bit_valid(bit_valid[2]),
    .sampler_stop(ss[2]), .rx_data(rd2), .rx_valid(rv[2]), .rx_ready(rx_ready[2]),
    .err_parity(ep[2]), .err_frame(ef[2]), .overrun(ov[2]), .clr_ovr(clr_ovr[2]),
    .dbg_state(dbg2));

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         d;
    logic [7:0] data;
    logic       par;
    logic       s0;
    logic       s1;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [7:0] rdata(input int d);
    case (d)
      0:       return rd0;
      1:       return rd1;
      default: return {3'b000, rd2};
    endcase
  endfunction

  function automatic int nbits(input int d);
    return (d == 2) ? 5 : 8;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Driver: one bit_valid strobe, then one idle clk. rdy / clr are raised
  // in the same clk as the strobe.
  task automatic send_bit(input int d, input logic b, input logic rdy, input logic clr);
    @(negedge clk);
    bit_in[d]    = b;
    bit_valid[d] = 1'b1;
    if (rdy) rx_ready[d] = 1'b1;
    if (clr) clr_ovr[d]  = 1'b1;
    @(negedge clk);
    bit_valid[d] = 1'b0;
    bit_in[d]    = 1'b1;
    rx_ready[d]  = 1'b0;
    clr_ovr[d]   = 1'b0;
  endtask

  // Returns in the clk right after the last stop bit was consumed.
  task automatic send_frame(input int d, input logic [7:0] data, input logic par,
                            input logic s0, input logic s1, input logic rdy_last,
                            input logic clr_last);
    send_bit(d, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbits(d); i++) send_bit(d, data[i], 1'b0, 1'b0);
    if (d != 0) send_bit(d, par, 1'b0, 1'b0);
    if (d == 2) begin
      send_bit(d, s0, 1'b0, 1'b0);
      chk($sformatf("d%0d sampler_stop after first stop", d), ss[d], 1'b0);
      send_bit(d, s1, rdy_last, clr_last);
    end else begin
      send_bit(d, s0, rdy_last, clr_last);
    end
  endtask

  task automatic accept(input int d);
    rx_ready[d] = 1'b1;
    @(negedge clk);
    rx_ready[d] = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s d%0d sampler_stop", tag, d), ss[d], 1'b0);
      chk($sformatf("%s d%0d rx_valid", tag, d), rv[d], 1'b0);
      chk($sformatf("%s d%0d rx_data", tag, d), rdata(d), 8'h00);
      chk($sformatf("%s d%0d err_parity", tag, d), ep[d], 1'b0);
      chk($sformatf("%s d%0d err_frame", tag, d), ef[d], 1'b0);
      chk($sformatf("%s d%0d overrun", tag, d), ov[d], 1'b0);
    end
  endtask

  initial begin
    vecs[0]  = '{0, 8'h55, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0};
    vecs[1]  = '{0, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b0, 1'b1};
    vecs[2]  = '{0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4]  = '{1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0};
    vecs[5]  = '{1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0};
    vecs[6]  = '{1, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[7]  = '{1, 8'h01, 1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
    vecs[8]  = '{2, 8'h15, 1'b0, 1'b1, 1'b1, 8'h15, 1'b0, 1'b0};
    vecs[9]  = '{2, 8'h15, 1'b1, 1'b1, 1'b1, 8'h15, 1'b1, 1'b0};
    vecs[10] = '{2, 8'h0C, 1'b1, 1'b1, 1'b0, 8'h0C, 1'b0, 1'b1};
    vecs[11] = '{2, 8'h0C, 1'b1, 1'b0, 1'b1, 8'h0C, 1'b0, 1'b1};
    vecs[12] = '{1, 8'hA3, 1'b1, 1'b0, 1'b1, 8'hA3, 1'b1, 1'b1};

    rst_n     = 1'b0;
    bit_in    = 3'b111;
    bit_valid = 3'b000;
    rx_ready  = 3'b000;
    clr_ovr   = 3'b000;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven frames
    for (int i = 0; i < 13; i++) begin
      send_frame(vecs[i].d, vecs[i].data, vecs[i].par, vecs[i].s0, vecs[i].s1, 1'b0, 1'b0);
      chk($sformatf("v%0d rx_valid", i), rv[vecs[i].d], 1'b1);
      chk($sformatf("v%0d sampler_stop", i), ss[vecs[i].d], 1'b1);
      chk($sformatf("v%0d rx_data", i), rdata(vecs[i].d), vecs[i].exp_data);
      chk($sformatf("v%0d err_parity", i), ep[vecs[i].d], vecs[i].exp_perr);
      chk($sformatf("v%0d err_frame", i), ef[vecs[i].d], vecs[i].exp_ferr);
      chk($sformatf("v%0d overrun", i), ov[vecs[i].d], 1'b0);
      accept(vecs[i].d);
      chk($sformatf("v%0d rx_valid after accept", i), rv[vecs[i].d], 1'b0);
      chk($sformatf("v%0d sampler_stop width", i), ss[vecs[i].d], 1'b0);
      chk($sformatf("v%0d rx_data held", i), rdata(vecs[i].d), vecs[i].exp_data);
    end

    // Overrun: the second frame is dropped while the first is held
    send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ovr first valid", rv[0], 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ovr data kept", rd0, 8'h11);
    chk("ovr valid kept", rv[0], 1'b1);
    chk("ovr flag set", ov[0], 1'b1);
    accept(0);
    chk("ovr valid cleared", rv[0], 1'b0);
    chk("ovr sticky", ov[0], 1'b1);
    clr_ovr[0] = 1'b1;
    @(negedge clk);
    clr_ovr[0] = 1'b0;
    chk("ovr cleared", ov[0], 1'b0);

    // A commit in the same clk as an accept loads the new frame, no overrun
    send_frame(0, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("accept+commit valid", rv[0], 1'b1);
    chk("accept+commit data", rd0, 8'h44);
    chk("accept+commit overrun", ov[0], 1'b0);
    accept(0);

    // Set wins over clr_ovr in the same clk
    send_frame(0, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'h66, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("set wins overrun", ov[0], 1'b1);
    chk("set wins data", rd0, 8'h55);
    clr_ovr[0] = 1'b1;
    @(negedge clk);
    clr_ovr[0] = 1'b0;
    chk("set wins later clear", ov[0], 1'b0);
    accept(0);

    // False start
    send_bit(0, 1'b1, 1'b0, 1'b0);
    chk("false start sampler_stop", ss[0], 1'b1);
    chk("false start rx_valid", rv[0], 1'b0);
    @(negedge clk);
    chk("false start pulse width", ss[0], 1'b0);
    send_frame(0, 8'h7E, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("after false start valid", rv[0], 1'b1);
    chk("after false start data", rd0, 8'h7E);
    accept(0);

    // Reset mid-frame: load held state and an overrun, then cut a frame short
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre-reset err_frame", ef[0], 1'b1);
    chk("pre-reset overrun", ov[0], 1'b1);
    send_bit(0, 1'b0, 1'b0, 1'b0);
    send_bit(0, 1'b1, 1'b0, 1'b0);
    send_bit(0, 1'b0, 1'b0, 1'b0);
    send_bit(0, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    chk("async reset state", {5'b0, dbg0}, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(0, 8'hC4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("post-reset valid", rv[0], 1'b1);
    chk("post-reset data", rd0, 8'hC4);
    chk("post-reset err_parity", ep[0], 1'b0);
    chk("post-reset err_frame", ef[0], 1'b0);
    chk("post-reset overrun", ov[0], 1'b0);
    accept(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
